// File: rtl/icache_ctrl.sv
// Direct-mapped instruction cache with a line-refill FSM for the IF stage.
// Lookup is combinational; misses fill a whole line, offset 0 first, over a ready-based read port.
module icache_ctrl #(
  parameter int IDX_BITS = 4,
  parameter int OFF_BITS = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fetch_en,
  input  logic [15:0] pc,
  input  logic        inv,
  output logic [15:0] instr,
  output logic        i_hit,
  output logic        mem_re,
  output logic [15:0] mem_addr,
  input  logic [15:0] mem_rdata,
  input  logic        mem_rdy
);

  localparam int TAG_BITS  = 16 - IDX_BITS - OFF_BITS;
  localparam int LINE_BITS = TAG_BITS + IDX_BITS;
  localparam int LINES     = 1 << IDX_BITS;
  localparam int WORDS     = 1 << OFF_BITS;

  typedef enum logic {IDLE, FILL} state_t;

  state_t                 state, state_nxt;
  logic [LINES-1:0]       valid;
  logic [TAG_BITS-1:0]    tag_mem  [LINES];
  logic [15:0]            data_mem [LINES*WORDS];
  logic [LINE_BITS-1:0]   fill_line;
  logic [OFF_BITS-1:0]    beat;

  logic [TAG_BITS-1:0]    pc_tag, fill_tag;
  logic [IDX_BITS-1:0]    pc_idx, fill_idx;
  logic [OFF_BITS-1:0]    pc_off;
  logic                   lookup_hit, miss, beat_done, last_beat;

  assign pc_tag   = pc[15 -: TAG_BITS];
  assign pc_idx   = pc[OFF_BITS +: IDX_BITS];
  assign pc_off   = pc[OFF_BITS-1:0];
  assign fill_tag = fill_line[LINE_BITS-1 -: TAG_BITS];
  assign fill_idx = fill_line[IDX_BITS-1:0];

  assign lookup_hit = valid[pc_idx] && (tag_mem[pc_idx] == pc_tag);
  // inv outranks miss detection, so an invalidating cycle never starts a fill.
  assign miss       = fetch_en && (state == IDLE) && !lookup_hit && !inv;
  assign beat_done  = (state == FILL) && mem_rdy && !inv;
  assign last_beat  = (beat == '1);

  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // NOTE: every always_comb output gets a default first, otherwise a latch is inferred.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (miss) state_nxt = FILL;
      FILL: if (inv || (beat_done && last_beat)) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Memory-side outputs come from registers only; no combinational path from pc.
  always_comb begin
    mem_re   = (state == FILL);
    mem_addr = {fill_line, beat};
    i_hit    = fetch_en && (state == IDLE) && lookup_hit;
    instr    = i_hit ? data_mem[{pc_idx, pc_off}] : 16'h0000;
  end

  // Valid is cleared on fill entry so a half-written line can never hit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid     <= '0;
      fill_line <= '0;
      beat      <= '0;
    end else begin
      if (inv)                         valid           <= '0;
      else if (miss)                   valid[pc_idx]   <= 1'b0;
      else if (beat_done && last_beat) valid[fill_idx] <= 1'b1;

      // beat holds on the last beat so mem_addr keeps its final value in IDLE.
      if (miss) begin
        fill_line <= {pc_tag, pc_idx};
        beat      <= '0;
      end else if (beat_done && !last_beat) begin
        beat <= beat + OFF_BITS'(1);
      end
    end
  end

  // NOTE: tag/data arrays are deliberately not reset; valid bits alone gate their use.
  always_ff @(posedge clk) begin
    if (beat_done)              data_mem[{fill_idx, beat}] <= mem_rdata;
    if (beat_done && last_beat) tag_mem[fill_idx]          <= fill_tag;
  end

endmodule

// File: tb/tb_icache_ctrl.sv
// Directed bench for icache_ctrl: inputs change and outputs are sampled just after the
// falling edge; the memory returns addr ^ 16'h5A5A for every word address.
module tb_icache_ctrl;

  logic        clk = 1'b0;
  logic        rst_n, fetch_en, inv, mem_rdy;
  logic [15:0] pc, mem_rdata;
  logic [15:0] instr, mem_addr;
  logic        i_hit, mem_re;

  int vectors     = 0;
  int miscompares = 0;

  icache_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .fetch_en  (fetch_en),
    .pc        (pc),
    .inv       (inv),
    .instr     (instr),
    .i_hit     (i_hit),
    .mem_re    (mem_re),
    .mem_addr  (mem_addr),
    .mem_rdata (mem_rdata),
    .mem_rdy   (mem_rdy)
  );

  always #5 clk = ~clk;

  always_comb mem_rdata = mem_addr ^ 16'h5A5A;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, miscompares so far %0d", miscompares);
    $fatal(1, "watchdog expired");
  end

  // Bounded wait for a hit on the current pc; an expired budget counts as a miscompare.
  task automatic wait_hit(input string name);
    int n;
    n = 0;
    while (i_hit !== 1'b1 && n < 40) begin
      @(negedge clk); #1;
      n++;
    end
    vectors++;
    if (i_hit !== 1'b1) begin
      miscompares++;
      $display("FAIL %s: i_hit=%b after %0d cycles, expected 1", name, i_hit, n);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; fetch_en = 1'b1; pc = 16'h0000; inv = 1'b0; mem_rdy = 1'b1;
    #1;
    vectors++; if (mem_re !== 1'b0) begin miscompares++; $display("FAIL rst_mem_re: got %b expected 0", mem_re); end
    vectors++; if (mem_addr !== 16'h0000) begin miscompares++; $display("FAIL rst_mem_addr: got %h expected 0000", mem_addr); end
    vectors++; if (i_hit !== 1'b0) begin miscompares++; $display("FAIL rst_i_hit: got %b expected 0", i_hit); end
    vectors++; if (instr !== 16'h0000) begin miscompares++; $display("FAIL rst_instr: got %h expected 0000", instr); end
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1; fetch_en = 1'b0;
  endtask

  task automatic test_cold_miss();
    @(negedge clk); pc = 16'h0123; fetch_en = 1'b1; mem_rdy = 1'b1; #1;
    vectors++; if (i_hit !== 1'b0) begin miscompares++; $display("FAIL cold_c0_hit: got %b expected 0", i_hit); end
    vectors++; if (mem_re !== 1'b0) begin miscompares++; $display("FAIL cold_c0_re: got %b expected 0", mem_re); end
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk); #1;
      vectors++; if (mem_re !== 1'b1) begin miscompares++; $display("FAIL cold_re c%0d: got %b expected 1", k, mem_re); end
      vectors++; if (mem_addr !== 16'h0120 + 16'(k-1)) begin miscompares++; $display("FAIL cold_addr c%0d: got %h expected %h", k, mem_addr, 16'h0120 + 16'(k-1)); end
      vectors++; if (i_hit !== 1'b0) begin miscompares++; $display("FAIL cold_hit c%0d: got %b expected 0", k, i_hit); end
    end
    @(negedge clk); #1;
    vectors++; if (i_hit !== 1'b1) begin miscompares++; $display("FAIL cold_c5_hit: got %b expected 1", i_hit); end
    vectors++; if (instr !== 16'h5B79) begin miscompares++; $display("FAIL cold_c5_instr: got %h expected 5b79", instr); end
    vectors++; if (mem_re !== 1'b0) begin miscompares++; $display("FAIL cold_c5_re: got %b expected 0", mem_re); end
    @(negedge clk); pc = 16'h0121; #1;
    vectors++; if (i_hit !== 1'b1 || instr !== 16'h5B7B) begin miscompares++; $display("FAIL cold_0121: hit=%b instr=%h expected 1 5b7b", i_hit, instr); end
    vectors++; if (mem_addr !== 16'h0123) begin miscompares++; $display("FAIL cold_addr_hold: got %h expected 0123", mem_addr); end
  endtask

  task automatic test_conflict();
    @(negedge clk); pc = 16'h0040; fetch_en = 1'b1; #1;
    wait_hit("conflict_fill_0040");
    vectors++; if (instr !== 16'h5A1A) begin miscompares++; $display("FAIL conflict_0040_instr: got %h expected 5a1a", instr); end
    @(negedge clk); pc = 16'h0440; #1;
    vectors++; if (i_hit !== 1'b0) begin miscompares++; $display("FAIL conflict_0440_miss: got %b expected 0", i_hit); end
    @(negedge clk); #1;
    vectors++; if (mem_re !== 1'b1 || mem_addr !== 16'h0440) begin miscompares++; $display("FAIL conflict_refill_start: re=%b addr=%h expected 1 0440", mem_re, mem_addr); end
    wait_hit("conflict_fill_0440");
    vectors++; if (instr !== 16'h5E1A) begin miscompares++; $display("FAIL conflict_0440_instr: got %h expected 5e1a", instr); end
    vectors++; if (mem_addr !== 16'h0443) begin miscompares++; $display("FAIL conflict_last_addr: got %h expected 0443", mem_addr); end
    @(negedge clk); pc = 16'h0040; #1;
    vectors++; if (i_hit !== 1'b0) begin miscompares++; $display("FAIL conflict_0040_evicted: got %b expected 0", i_hit); end
    fetch_en = 1'b0;
    @(negedge clk); #1;
    vectors++; if (mem_re !== 1'b0) begin miscompares++; $display("FAIL conflict_no_fill: got %b expected 0", mem_re); end
  endtask

  task automatic test_wait_states();
    @(negedge clk); mem_rdy = 1'b0; pc = 16'h0080; fetch_en = 1'b1; #1;
    vectors++; if (i_hit !== 1'b0) begin miscompares++; $display("FAIL wait_c0_hit: got %b expected 0", i_hit); end
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk); mem_rdy = (k % 3 == 0); #1;
      vectors++; if (mem_re !== 1'b1) begin miscompares++; $display("FAIL wait_re c%0d: got %b expected 1", k, mem_re); end
      vectors++; if (mem_addr !== 16'h0080 + 16'((k-1)/3)) begin miscompares++; $display("FAIL wait_addr c%0d: got %h expected %h", k, mem_addr, 16'h0080 + 16'((k-1)/3)); end
      vectors++; if (i_hit !== 1'b0) begin miscompares++; $display("FAIL wait_hit c%0d: got %b expected 0", k, i_hit); end
    end
    @(negedge clk); mem_rdy = 1'b1; #1;
    vectors++; if (i_hit !== 1'b1 || instr !== 16'h5ADA) begin miscompares++; $display("FAIL wait_c13: hit=%b instr=%h expected 1 5ada", i_hit, instr); end
    vectors++; if (mem_re !== 1'b0) begin miscompares++; $display("FAIL wait_c13_re: got %b expected 0", mem_re); end
  endtask

  // 0x0300 shares index 0 with 0x0200 at the default geometry, so the jump target is
  // 0x0304 (index 1) to show the original line survives and then hits without traffic.
  task automatic test_pc_jump();
    @(negedge clk); pc = 16'h0200; fetch_en = 1'b1; #1;
    vectors++; if (i_hit !== 1'b0) begin miscompares++; $display("FAIL jump_c0_hit: got %b expected 0", i_hit); end
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk); if (k == 2) pc = 16'h0304; #1;
      vectors++; if (mem_re !== 1'b1 || mem_addr !== 16'h0200 + 16'(k-1)) begin miscompares++; $display("FAIL jump_fill c%0d: re=%b addr=%h expected 1 %h", k, mem_re, mem_addr, 16'h0200 + 16'(k-1)); end
    end
    @(negedge clk); #1;
    vectors++; if (i_hit !== 1'b0) begin miscompares++; $display("FAIL jump_new_miss: got %b expected 0", i_hit); end
    @(negedge clk); #1;
    vectors++; if (mem_re !== 1'b1 || mem_addr !== 16'h0304) begin miscompares++; $display("FAIL jump_new_fill: re=%b addr=%h expected 1 0304", mem_re, mem_addr); end
    wait_hit("jump_fill_0304");
    vectors++; if (instr !== 16'h595E) begin miscompares++; $display("FAIL jump_0304_instr: got %h expected 595e", instr); end
    @(negedge clk); pc = 16'h0200; #1;
    vectors++; if (i_hit !== 1'b1 || instr !== 16'h585A) begin miscompares++; $display("FAIL jump_0200_hit: hit=%b instr=%h expected 1 585a", i_hit, instr); end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); #1;
      vectors++; if (mem_re !== 1'b0) begin miscompares++; $display("FAIL jump_no_traffic c%0d: got %b expected 0", k, mem_re); end
    end
  endtask

  task automatic test_inv();
    // inv in IDLE outranks a miss on the same cycle.
    @(negedge clk); pc = 16'h0048; fetch_en = 1'b1; inv = 1'b1; #1;
    vectors++; if (i_hit !== 1'b0) begin miscompares++; $display("FAIL inv_idle_hit: got %b expected 0", i_hit); end
    @(negedge clk); inv = 1'b0; #1;
    vectors++; if (mem_re !== 1'b0) begin miscompares++; $display("FAIL inv_idle_no_fill: got %b expected 0", mem_re); end
    // This cycle is cycle 0 of the fill; inv coincides with the 3rd mem_rdy.
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk); inv = (k == 3); #1;
      vectors++; if (mem_addr !== 16'h0048 + 16'(k-1)) begin miscompares++; $display("FAIL inv_fill_addr c%0d: got %h expected %h", k, mem_addr, 16'h0048 + 16'(k-1)); end
    end
    @(negedge clk); inv = 1'b0; #1;
    vectors++; if (mem_re !== 1'b0 || i_hit !== 1'b0) begin miscompares++; $display("FAIL inv_abort: re=%b hit=%b expected 0 0", mem_re, i_hit); end
    vectors++; if (mem_addr !== 16'h004A) begin miscompares++; $display("FAIL inv_abort_addr: got %h expected 004a", mem_addr); end
    @(negedge clk); #1;
    vectors++; if (mem_re !== 1'b1 || mem_addr !== 16'h0048) begin miscompares++; $display("FAIL inv_refill_off0: re=%b addr=%h expected 1 0048", mem_re, mem_addr); end
    wait_hit("inv_refill_0048");
    vectors++; if (instr !== 16'h5A12) begin miscompares++; $display("FAIL inv_0048_instr: got %h expected 5a12", instr); end
    @(negedge clk); pc = 16'h0123; #1;
    vectors++; if (i_hit !== 1'b0) begin miscompares++; $display("FAIL inv_old_0123: got %b expected 0", i_hit); end
    pc = 16'h0200; #1;
    vectors++; if (i_hit !== 1'b0) begin miscompares++; $display("FAIL inv_old_0200: got %b expected 0", i_hit); end
    fetch_en = 1'b0;
  endtask

  task automatic test_reset_mid_fill();
    @(negedge clk); pc = 16'h0123; fetch_en = 1'b1; #1;
    @(negedge clk); @(negedge clk); #1;
    vectors++; if (mem_re !== 1'b1) begin miscompares++; $display("FAIL rstfill_in_fill: got %b expected 1", mem_re); end
    rst_n = 1'b0; #1;
    vectors++; if (mem_re !== 1'b0 || i_hit !== 1'b0 || instr !== 16'h0000) begin miscompares++; $display("FAIL rstfill_outputs: re=%b hit=%b instr=%h expected 0 0 0000", mem_re, i_hit, instr); end
    vectors++; if (mem_addr !== 16'h0000) begin miscompares++; $display("FAIL rstfill_addr: got %h expected 0000", mem_addr); end
    @(negedge clk); rst_n = 1'b1; pc = 16'h0200; #1;
    vectors++; if (i_hit !== 1'b0) begin miscompares++; $display("FAIL rstfill_0200_miss: got %b expected 0", i_hit); end
    pc = 16'h0048; #1;
    vectors++; if (i_hit !== 1'b0) begin miscompares++; $display("FAIL rstfill_0048_miss: got %b expected 0", i_hit); end
    wait_hit("rstfill_refill_0048");
    fetch_en = 1'b0; #1;
    vectors++; if (i_hit !== 1'b0 || instr !== 16'h0000) begin miscompares++; $display("FAIL fetch_dis: hit=%b instr=%h expected 0 0000", i_hit, instr); end
    for (int k = 0; k < 2; k++) begin
      @(negedge clk); #1;
      vectors++; if (mem_re !== 1'b0) begin miscompares++; $display("FAIL fetch_dis_no_fill c%0d: got %b expected 0", k, mem_re); end
    end
  endtask

  task automatic test_index_wrap();
    @(negedge clk); pc = 16'h003C; fetch_en = 1'b1; #1;
    wait_hit("wrap_fill_003c");
    vectors++; if (mem_addr !== 16'h003F) begin miscompares++; $display("FAIL wrap_last_addr: got %h expected 003f", mem_addr); end
    @(negedge clk); pc = 16'h0000; #1;
    wait_hit("wrap_fill_0000");
    vectors++; if (instr !== 16'h5A5A) begin miscompares++; $display("FAIL wrap_0000_instr: got %h expected 5a5a", instr); end
    @(negedge clk); pc = 16'h003F; #1;
    vectors++; if (i_hit !== 1'b1 || instr !== 16'h5A65) begin miscompares++; $display("FAIL wrap_003f_hit: hit=%b instr=%h expected 1 5a65", i_hit, instr); end
    fetch_en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_cold_miss();
    test_conflict();
    test_wait_states();
    test_pc_jump();
    test_inv();
    test_reset_mid_fill();
    test_index_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
